// File: rtl/tia_cpu_clock_controller_pkg.sv
// Shared timing constants and FSM state encoding for the TIA CPU clock
// controller and its line counter.
package tia_cpu_clock_controller_pkg;

    localparam int TIA_LINE_CLOCKS = 228;  // color clocks per scanline
    localparam int TIA_DIV         = 3;    // color clocks per CPU cycle

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALT   = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tia_cpu_clock_controller_if.sv
// CPU-facing strobe/status bundle of the TIA CPU clock controller.
// The CPU side uses the master modport, the controller the slave modport.
// Optional halt statistics appear when TIA_HALT_STATS_EN is defined.
interface tia_cpu_clock_controller_if #(
    parameter int HW = 8
);
    logic          wsync_strobe;
    logic          rsync_strobe;
    logic          phi0_en;
    logic          rdy;
    logic          resphi0;
    logic [HW-1:0] hcount;
    logic          line_start;
`ifdef TIA_HALT_STATS_EN
    logic [15:0]   halt_cycles;
    logic [7:0]    halt_count;

    modport master (
        output wsync_strobe, rsync_strobe,
        input  phi0_en, rdy, resphi0, hcount, line_start, halt_cycles, halt_count
    );
    modport slave (
        input  wsync_strobe, rsync_strobe,
        output phi0_en, rdy, resphi0, hcount, line_start, halt_cycles, halt_count
    );
`else
    modport master (
        output wsync_strobe, rsync_strobe,
        input  phi0_en, rdy, resphi0, hcount, line_start
    );
    modport slave (
        input  wsync_strobe, rsync_strobe,
        output phi0_en, rdy, resphi0, hcount, line_start
    );
`endif
endinterface

// File: rtl/tia_line_counter.sv
// Mod-LINE_CLOCKS color-clock position counter. A clear restarts the line
// and takes priority over the normal increment. HW must satisfy
// 2**HW >= LINE_CLOCKS.
module tia_line_counter
    import tia_cpu_clock_controller_pkg::*;
#(
    parameter int LINE_CLOCKS = TIA_LINE_CLOCKS,
    parameter int HW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    output logic [HW-1:0] hcount,
    output logic          line_start,
    output logic          last
);
    localparam logic [HW-1:0] LAST_H = HW'(LINE_CLOCKS - 1);

    // Advance one position per color clock, wrapping at the end of the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               hcount <= '0;
        else if (clear)          hcount <= '0;
        else if (hcount == LAST_H) hcount <= '0;
        else                     hcount <= hcount + 1'b1;
    end

    assign line_start = (hcount == '0);
    assign last       = (hcount == LAST_H);

endmodule

// File: rtl/tia_cpu_clock_controller.sv
// TIA CPU clock controller: divides the color clock into phi0 enables,
// tracks the scanline position and runs the RUN/HALT/RESYNC FSM that
// services WSYNC (stall CPU to next line) and RSYNC (re-phase divider and
// restart the line). Strobes are only honoured on a phi0_en clock.
// Optional feature macro: TIA_HALT_STATS_EN adds halt_cycles/halt_count.
module tia_cpu_clock_controller
    import tia_cpu_clock_controller_pkg::*;
#(
    parameter int LINE_CLOCKS = TIA_LINE_CLOCKS,
    parameter int DIV         = TIA_DIV,
    parameter int HW          = 8
) (
    input  logic clk,
    input  logic reset,
    tia_cpu_clock_controller_if.slave bus
);
    localparam int            PW      = cnt_width(DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    state_t        state, next_state;
    logic [PW-1:0] ph;
    logic          phi0_en;
    logic          enter_resync;
    logic          resphi0;
    logic [HW-1:0] hcount;
    logic          line_start;
    logic          last;

    // The RESYNC clock never ends a CPU cycle.
    assign phi0_en      = (ph == PH_LAST) && (state != ST_RESYNC);
    assign enter_resync = (next_state == ST_RESYNC);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= next_state;
    end

    // FSM next state; RSYNC beats WSYNC, a WSYNC on the last clock of the
    // line would halt for zero clocks so it is simply dropped.
    always_comb begin
        next_state = state;
        case (state)
            ST_RUN: begin
                if (bus.rsync_strobe && phi0_en)
                    next_state = ST_RESYNC;
                else if (bus.wsync_strobe && phi0_en && !last)
                    next_state = ST_HALT;
            end
            ST_HALT:   if (last) next_state = ST_RUN;
            ST_RESYNC: next_state = ST_RUN;
            default:   next_state = ST_RUN;
        endcase
    end

    // Phase divider; forced to 0 on the edge into RESYNC so the RESYNC
    // clock is phase 0 and the next phi0_en lands DIV-1 clocks later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             ph <= '0;
        else if (enter_resync || ph == PH_LAST) ph <= '0;
        else                                   ph <= ph + 1'b1;
    end

    // Registered divider-phase reset, high exactly during the RESYNC clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) resphi0 <= 1'b1;
        else       resphi0 <= enter_resync;
    end

    tia_line_counter #(
        .LINE_CLOCKS (LINE_CLOCKS),
        .HW          (HW)
    ) u_line (
        .clk        (clk),
        .reset      (reset),
        .clear      (enter_resync),
        .hcount     (hcount),
        .line_start (line_start),
        .last       (last)
    );

    assign bus.phi0_en    = phi0_en;
    assign bus.rdy        = (state != ST_HALT);
    assign bus.resphi0    = resphi0;
    assign bus.hcount     = hcount;
    assign bus.line_start = line_start;

`ifdef TIA_HALT_STATS_EN
    logic [15:0] halt_cycles;
    logic [7:0]  halt_count;
    logic        accept_wsync;

    assign accept_wsync = (state == ST_RUN) && (next_state == ST_HALT);

    // Halted phi0 periods (saturating, cleared by RSYNC) and accepted WSYNCs (wrapping).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_cycles <= '0;
            halt_count  <= '0;
        end else begin
            if (enter_resync)
                halt_cycles <= '0;
            else if (state == ST_HALT && phi0_en && halt_cycles != 16'hFFFF)
                halt_cycles <= halt_cycles + 16'd1;
            if (accept_wsync)
                halt_count <= halt_count + 8'd1;
        end
    end

    assign bus.halt_cycles = halt_cycles;
    assign bus.halt_count  = halt_count;
`endif

endmodule

// File: tb/tb_tia_cpu_clock_controller.sv
// Directed bench for tia_cpu_clock_controller: free-running line/phase,
// WSYNC halts, RSYNC re-phase, strobe boundaries and async reset, plus the
// halt statistics when TIA_HALT_STATS_EN is defined.
module tb_tia_cpu_clock_controller;

    localparam int LC = 228;
    localparam int DV = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tia_cpu_clock_controller_if #(.HW(8)) bus ();

    tia_cpu_clock_controller #(
        .LINE_CLOCKS (LC),
        .DIV         (DV),
        .HW          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   adv;    // free-running clocks before this vector
        logic wsync;
        logic rsync;
        int   h;      // expected hcount after the edge
        int   ph;     // phase after the edge (keeps the bench model in step)
        logic phi0;
        logic rdy;
        logic res;
        logic ls;
    } vec_t;

    localparam int NV = 16;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_h    = 0;
    int   exp_ph   = 0;
    logic exp_rdy  = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string nm, input logic e_phi0, input logic e_rdy,
                             input logic e_res, input logic e_ls, input int e_h);
        n_checks++;
        if (bus.phi0_en === e_phi0 && bus.rdy === e_rdy && bus.resphi0 === e_res &&
            bus.line_start === e_ls && bus.hcount === 8'(e_h))
            n_pass++;
        else
            $display("FAIL %s: got phi0_en=%b rdy=%b resphi0=%b line_start=%b hcount=%0d, want phi0_en=%b rdy=%b resphi0=%b line_start=%b hcount=%0d",
                     nm, bus.phi0_en, bus.rdy, bus.resphi0, bus.line_start, bus.hcount,
                     e_phi0, e_rdy, e_res, e_ls, e_h);
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    // One clock of free running: line and phase advance, a halt ends at line wrap.
    task automatic model_step(input string nm);
        tick();
        exp_h  = (exp_h + 1) % LC;
        exp_ph = (exp_ph + 1) % DV;
        if (exp_h == 0) exp_rdy = 1'b1;
        check_vec(nm, exp_ph == DV - 1, exp_rdy, 1'b0, exp_h == 0, exp_h);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [NV];
        int   low, guard, n_ls, n_phi;

        //           adv  w     r     h    ph  phi0  rdy   res   ls
        tbl[0]  = '{227, 1'b1, 1'b0,   0, 0, 1'b0, 1'b1, 1'b0, 1'b1}; // WSYNC on last clk dropped
        tbl[1]  = '{  0, 1'b0, 1'b0,   1, 1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{  0, 1'b0, 1'b0,   2, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{ 98, 1'b0, 1'b1, 101, 2, 1'b1, 1'b1, 1'b0, 1'b0}; // RSYNC at h=100, phi0_en=0
        tbl[4]  = '{  0, 1'b0, 1'b1,   0, 0, 1'b0, 1'b1, 1'b1, 1'b1}; // RSYNC at h=101 -> RESYNC
        tbl[5]  = '{  0, 1'b0, 1'b0,   1, 1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{  0, 1'b0, 1'b0,   2, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{  0, 1'b0, 1'b0,   3, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{224, 1'b0, 1'b0,   0, 0, 1'b0, 1'b1, 1'b0, 1'b1}; // 227 clks after h=1
        tbl[9]  = '{  2, 1'b1, 1'b1,   0, 0, 1'b0, 1'b1, 1'b1, 1'b1}; // both strobes: RSYNC wins
        tbl[10] = '{  0, 1'b0, 1'b0,   1, 1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{  0, 1'b0, 1'b0,   2, 2, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{  0, 1'b0, 1'b0,   3, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{  0, 1'b1, 1'b0,   4, 1, 1'b0, 1'b1, 1'b0, 1'b0}; // WSYNC with phi0_en=0
        tbl[14] = '{  0, 1'b1, 1'b0,   5, 2, 1'b1, 1'b1, 1'b0, 1'b0}; // WSYNC with phi0_en=0
        tbl[15] = '{  0, 1'b0, 1'b0,   6, 0, 1'b0, 1'b1, 1'b0, 1'b0};

        bus.wsync_strobe = 1'b0;
        bus.rsync_strobe = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset", 1'b0, 1'b1, 1'b1, 1'b1, 0);
`ifdef TIA_HALT_STATS_EN
        chk_int("halt_cycles_reset", int'(bus.halt_cycles), 0);
        chk_int("halt_count_reset", int'(bus.halt_count), 0);
`endif
        #3 reset = 1'b0;
        #1 check_vec("post_release", 1'b0, 1'b1, 1'b1, 1'b1, 0);

        // Three free-running lines.
        n_ls  = 0;
        n_phi = 0;
        for (int i = 0; i < 3 * LC; i++) begin
            model_step("free_run");
            if (bus.line_start === 1'b1) n_ls++;
            if (bus.phi0_en === 1'b1) n_phi++;
        end
        chk_int("line_starts_3_lines", n_ls, 3);
        chk_int("phi0_en_3_lines", n_phi, LC);

        // WSYNC at hcount=20; an RSYNC during the halt must be ignored.
        repeat (20) model_step("to_h20");
        bus.wsync_strobe = 1'b1;
        exp_rdy = 1'b0;
        model_step("wsync_h20");
        bus.wsync_strobe = 1'b0;
        low   = (bus.rdy === 1'b0) ? 1 : 0;
        guard = 0;
        while (bus.rdy === 1'b0 && guard < 300) begin
            bus.rsync_strobe = (exp_h == 50);
            model_step("halt_h20");
            bus.rsync_strobe = 1'b0;
            guard++;
            if (bus.rdy === 1'b0) low++;
        end
        chk_int("halt_len_h20", low, 207);
        chk_int("rdy_after_halt", int'(bus.rdy), 1);

        // Table: WSYNC at last clock, RSYNC re-phase, strobe collisions.
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < tbl[i].adv; k++) model_step($sformatf("adv%0d", i));
            bus.wsync_strobe = tbl[i].wsync;
            bus.rsync_strobe = tbl[i].rsync;
            tick();
            bus.wsync_strobe = 1'b0;
            bus.rsync_strobe = 1'b0;
            check_vec($sformatf("vec%0d", i), tbl[i].phi0, tbl[i].rdy, tbl[i].res,
                      tbl[i].ls, tbl[i].h);
            exp_h   = tbl[i].h;
            exp_ph  = tbl[i].ph;
            exp_rdy = tbl[i].rdy;
        end

        // Halt at hcount=8, then reset asynchronously at hcount=50.
        repeat (2) model_step("to_h8");
        bus.wsync_strobe = 1'b1;
        exp_rdy = 1'b0;
        model_step("wsync_h8");
        bus.wsync_strobe = 1'b0;
        repeat (41) model_step("halt_h8");
        #2 reset = 1'b1;
        #1 check_vec("async_reset_mid_halt", 1'b0, 1'b1, 1'b1, 1'b1, 0);
`ifdef TIA_HALT_STATS_EN
        chk_int("halt_cycles_async_reset", int'(bus.halt_cycles), 0);
`endif
        tick();
        check_vec("reset_held", 1'b0, 1'b1, 1'b1, 1'b1, 0);
        #3 reset = 1'b0;
        exp_h   = 0;
        exp_ph  = 0;
        exp_rdy = 1'b1;

        // WSYNC at hcount=2 halts for 225 clocks.
        repeat (2) model_step("to_h2");
        bus.wsync_strobe = 1'b1;
        exp_rdy = 1'b0;
        model_step("wsync_h2");
        bus.wsync_strobe = 1'b0;
        low   = (bus.rdy === 1'b0) ? 1 : 0;
        guard = 0;
        while (bus.rdy === 1'b0 && guard < 300) begin
            model_step("halt_h2");
            guard++;
            if (bus.rdy === 1'b0) low++;
        end
        chk_int("halt_len_h2", low, 225);
`ifdef TIA_HALT_STATS_EN
        chk_int("halt_cycles_h2", int'(bus.halt_cycles), 75);
        chk_int("halt_count_h2", int'(bus.halt_count), 1);
`endif

        // RSYNC clears the halted-cycle count.
        repeat (2) model_step("to_h2_b");
        bus.rsync_strobe = 1'b1;
        tick();
        bus.rsync_strobe = 1'b0;
        check_vec("resync_after_halt", 1'b0, 1'b1, 1'b1, 1'b1, 0);
`ifdef TIA_HALT_STATS_EN
        chk_int("halt_cycles_cleared", int'(bus.halt_cycles), 0);
        chk_int("halt_count_kept", int'(bus.halt_count), 1);
`endif
        exp_h  = 0;
        exp_ph = 0;
        repeat (3) model_step("after_resync");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
